// File: rtl/ddr_native_pkg.sv
// Shared command encodings, packet field offsets and state type for the DDR native port arbiter.
package ddr_native_pkg;

    localparam logic [2:0] DDR_CMD_WR = 3'b000;
    localparam logic [2:0] DDR_CMD_RD = 3'b001;

    localparam int DEFAULT_NUM_PORTS = 4;
    typedef logic [$clog2(DEFAULT_NUM_PORTS)-1:0] port_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARB  = 2'b01,
        ST_BUSY = 2'b10
    } arb_state_t;

    // Packed beat layout is {cmd[2:0], addr, data} with data in the low bits.
    function automatic int cmd_lsb(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/common_fifo.sv
// First-word-fall-through FIFO with occupancy counter; DEPTH must be a power of two (>= 2).
module common_fifo #(
    parameter int DEPTH = 16,
    parameter int DSIZE = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DSIZE-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == '0);
    assign push_s  = wr_en & ~full;
    assign pop_s   = rd_en & ~empty;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ddr_native_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one DDR native command stream among NUM_PORTS
// requesters, with in-order routing of read returns through a port-id tag FIFO.
module ddr_native_port_arbiter
    import ddr_native_pkg::*;
#(
    parameter int  NUM_PORTS  = 4,
    parameter int  ADDR_WIDTH = 27,
    parameter int  DATA_WIDTH = 256,
    parameter int  TAG_DEPTH  = 16,
    localparam int DSIZE      = 3 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic [DSIZE-1:0]      s_tdata [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]  s_tvalid,
    input  logic [NUM_PORTS-1:0]  s_tlast,
    output logic [NUM_PORTS-1:0]  s_tready,
    output logic [DSIZE-1:0]      m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic [DATA_WIDTH-1:0] rd_tdata,
    input  logic                  rd_tvalid,
    input  logic                  rd_tlast,
    output logic                  rd_tready,
    output logic [DATA_WIDTH-1:0] r_tdata,
    output logic [NUM_PORTS-1:0]  r_tvalid,
    output logic [NUM_PORTS-1:0]  r_tlast,
    input  logic [NUM_PORTS-1:0]  r_tready
);

    localparam int PW      = $clog2(NUM_PORTS);
    localparam int CMD_LSB = cmd_lsb(ADDR_WIDTH, DATA_WIDTH);

    typedef logic [PW-1:0] pid_t;

    arb_state_t           state_r;
    pid_t                 grant_r;
    pid_t                 rr_ptr_r;
    logic                 first_beat_r;
    logic [NUM_PORTS-1:0] elig_s;
    logic [PW:0]          pick_s;
    logic                 pick_found_s;
    pid_t                 pick_port_s;
    logic                 m_hs_s;
    logic                 tag_push_s;
    logic                 tag_pop_s;
    logic                 tag_full_s;
    logic                 tag_empty_s;
    pid_t                 tag_head_s;

    // Scan from ptr upward with wrap; iterating in reverse lets the nearest requester win.
    function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req, input pid_t ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) res = {1'b1, pid_t'(idx)};
        end
        return res;
    endfunction

    // A read packet may only win while the tag FIFO has room for its port id.
    always_comb begin
        elig_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (s_tvalid[p] && ((s_tdata[p][CMD_LSB +: 3] != DDR_CMD_RD) || !tag_full_s)) begin
                elig_s[p] = 1'b1;
            end else begin
                elig_s[p] = 1'b0;
            end
        end
    end

    assign pick_s       = rr_pick(elig_s, rr_ptr_r);
    assign pick_found_s = pick_s[PW];
    assign pick_port_s  = pick_s[PW-1:0];

    // Arbitration FSM: one ARB bubble per packet, grant held until the tlast handshake.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            rr_ptr_r     <= '0;
            first_beat_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (init_calib_complete) state_r <= ST_ARB;
                    else                     state_r <= ST_IDLE;
                end
                ST_ARB: begin
                    if (!init_calib_complete) begin
                        state_r <= ST_IDLE;
                    end else if (pick_found_s) begin
                        grant_r      <= pick_port_s;
                        rr_ptr_r     <= (int'(pick_port_s) == NUM_PORTS - 1) ? '0 : pid_t'(pick_port_s + 1'b1);
                        first_beat_r <= 1'b1;
                        state_r      <= ST_BUSY;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_BUSY: begin
                    if (m_hs_s) begin
                        first_beat_r <= 1'b0;
                        if (m_tlast) state_r <= init_calib_complete ? ST_ARB : ST_IDLE;
                        else         state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    first_beat_r <= 1'b0;
                end
            endcase
        end
    end

    // Command path: only the granted port is connected while a packet is in flight.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state_r == ST_BUSY) begin
            m_tdata           = s_tdata[grant_r];
            m_tvalid          = s_tvalid[grant_r];
            m_tlast           = s_tlast[grant_r];
            s_tready[grant_r] = m_tready;
        end else begin
            s_tready = '0;
        end
    end

    assign m_hs_s     = m_tvalid & m_tready;
    assign tag_push_s = m_hs_s & first_beat_r & (m_tdata[CMD_LSB +: 3] == DDR_CMD_RD);

    // Read return steered to the port at the tag head; nothing is accepted without a tag.
    always_comb begin
        r_tvalid  = '0;
        r_tlast   = '0;
        rd_tready = 1'b0;
        if (!tag_empty_s) begin
            r_tvalid[tag_head_s] = rd_tvalid;
            r_tlast[tag_head_s]  = rd_tlast;
            rd_tready            = r_tready[tag_head_s];
        end else begin
            rd_tready = 1'b0;
        end
    end

    assign r_tdata   = rd_tdata;
    assign tag_pop_s = rd_tvalid & rd_tready & rd_tlast;

    common_fifo #(
        .DEPTH (TAG_DEPTH),
        .DSIZE (PW)
    ) u_tag_fifo (
        .clock   (clock),
        .rst_n   (~rst),
        .srst    (1'b0),
        .wr_en   (tag_push_s),
        .wr_data (grant_r),
        .rd_en   (tag_pop_s),
        .rd_data (tag_head_s),
        .full    (tag_full_s),
        .empty   (tag_empty_s)
    );

endmodule
